// File: rtl/axi_demux_id_tracker.sv
// Per-ID outstanding-transaction tracker for one direction of an AXI demux slave port.
// Records the master port each in-flight ID targets and how many are outstanding, and
// holds off a new request whose ID is already in flight to another port or is at its limit.
module axi_demux_id_tracker #(
  parameter int unsigned IdUsedWidth = 3,
  parameter int unsigned NoMstPorts  = 4,
  parameter int unsigned MaxTrans    = 8,
  parameter bit          UniqueIds   = 1'b0,
  localparam int unsigned SelWidth   = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1,
  localparam int unsigned CntWidth   = $clog2(MaxTrans + 1),
  localparam int unsigned NumIds     = 2 ** IdUsedWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_valid_i,
  input  logic [IdUsedWidth-1:0] push_id_i,
  input  logic [SelWidth-1:0]    push_sel_i,
  output logic                   push_ready_o,
  input  logic                   pop_valid_i,
  input  logic [IdUsedWidth-1:0] pop_id_i,
  output logic                   idle_o,
  output logic [NumIds-1:0]      id_busy_o,
  output logic                   err_underflow_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxTrans);

  logic [CntWidth-1:0] cnt_q [NumIds];
  logic [CntWidth-1:0] cnt_d [NumIds];
  logic [SelWidth-1:0] sel_q [NumIds];
  logic [SelWidth-1:0] sel_d [NumIds];
  logic                err_q, err_d;

  logic [CntWidth-1:0] push_cnt;
  logic                push_fire;

  // Admission check for the presented request; ignores push_valid_i on purpose.
  always_comb begin
    push_cnt = cnt_q[push_id_i];
    if (UniqueIds) begin
      push_ready_o = (push_cnt < MaxCnt);
    end else begin
      push_ready_o = (push_cnt == '0) ||
                     ((sel_q[push_id_i] == push_sel_i) && (push_cnt < MaxCnt));
    end
    push_fire = push_valid_i && push_ready_o;
  end

  // Per-ID counter and port bookkeeping; pops on an empty counter saturate and flag an error.
  always_comb begin
    err_d = err_q;
    if (pop_valid_i && (cnt_q[pop_id_i] == '0)) begin
      err_d = 1'b1;
    end
    for (int unsigned i = 0; i < NumIds; i++) begin
      logic inc;
      logic dec;
      cnt_d[i] = cnt_q[i];
      sel_d[i] = sel_q[i];
      inc = push_fire && (push_id_i == IdUsedWidth'(i));
      dec = pop_valid_i && (pop_id_i == IdUsedWidth'(i)) && (cnt_q[i] != '0);
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
      if (inc) begin
        sel_d[i] = push_sel_i;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumIds; i++) begin
        cnt_q[i] <= '0;
        sel_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NumIds; i++) begin
        cnt_q[i] <= cnt_d[i];
        sel_q[i] <= sel_d[i];
      end
      err_q <= err_d;
    end
  end

  // Status outputs derived from registered counters only.
  always_comb begin
    for (int unsigned i = 0; i < NumIds; i++) begin
      id_busy_o[i] = (cnt_q[i] != '0);
    end
    idle_o          = ~|id_busy_o;
    err_underflow_o = err_q;
  end

endmodule

// File: tb/tb_axi_demux_id_tracker.sv
// Scoreboard bench for axi_demux_id_tracker: one instance with the port-mismatch check,
// one with UniqueIds=1. Stimulus queues expected values; a monitor compares at negedge.
module tb_axi_demux_id_tracker;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       a_push_valid, a_push_ready, a_pop_valid, a_idle, a_err;
  logic [2:0] a_push_id, a_pop_id;
  logic [1:0] a_push_sel;
  logic [7:0] a_busy;

  logic       b_push_valid, b_push_ready, b_pop_valid, b_idle, b_err;
  logic [2:0] b_push_id, b_pop_id;
  logic [1:0] b_push_sel;
  logic [7:0] b_busy;

  always #5 clk = ~clk;

  axi_demux_id_tracker #(
    .IdUsedWidth(3), .NoMstPorts(4), .MaxTrans(8), .UniqueIds(1'b0)
  ) u_dut_a (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .push_valid_i   (a_push_valid),
    .push_id_i      (a_push_id),
    .push_sel_i     (a_push_sel),
    .push_ready_o   (a_push_ready),
    .pop_valid_i    (a_pop_valid),
    .pop_id_i       (a_pop_id),
    .idle_o         (a_idle),
    .id_busy_o      (a_busy),
    .err_underflow_o(a_err)
  );

  axi_demux_id_tracker #(
    .IdUsedWidth(3), .NoMstPorts(4), .MaxTrans(8), .UniqueIds(1'b1)
  ) u_dut_b (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .push_valid_i   (b_push_valid),
    .push_id_i      (b_push_id),
    .push_sel_i     (b_push_sel),
    .push_ready_o   (b_push_ready),
    .pop_valid_i    (b_pop_valid),
    .pop_id_i       (b_pop_id),
    .idle_o         (b_idle),
    .id_busy_o      (b_busy),
    .err_underflow_o(b_err)
  );

  // Kinds: 0 a.ready, 1 a.idle, 2 a.busy, 3 a.err, 4 b.ready, 5 b.busy, 6 b.idle
  typedef struct {
    int         kind;
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_test = 0;
  int   n_fail = 0;

  task automatic expect_val(input int kind, input string name, input logic [7:0] val);
    exp_t e;
    e.kind = kind;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Monitor: drains every expectation queued since the last falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t       e;
      logic [7:0] act;
      e = exp_q.pop_front();
      case (e.kind)
        0:       act = {7'd0, a_push_ready};
        1:       act = {7'd0, a_idle};
        2:       act = a_busy;
        3:       act = {7'd0, a_err};
        4:       act = {7'd0, b_push_ready};
        5:       act = b_busy;
        default: act = {7'd0, b_idle};
      endcase
      n_test++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %02h expected %02h", e.name, act, e.val);
      end
    end
  end

  // Advance to just after a rising edge and drop all one-shot strobes.
  task automatic step();
    @(posedge clk);
    #1;
    a_push_valid = 1'b0;
    a_pop_valid  = 1'b0;
    b_push_valid = 1'b0;
    b_pop_valid  = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic a_push(input logic [2:0] id, input logic [1:0] sel);
    a_push_valid = 1'b1;
    a_push_id    = id;
    a_push_sel   = sel;
  endtask

  task automatic a_pop(input logic [2:0] id);
    a_pop_valid = 1'b1;
    a_pop_id    = id;
  endtask

  initial begin
    rst_n        = 1'b0;
    a_push_valid = 1'b0; a_push_id = '0; a_push_sel = '0; a_pop_valid = 1'b0; a_pop_id = '0;
    b_push_valid = 1'b0; b_push_id = '0; b_push_sel = '0; b_pop_valid = 1'b0; b_pop_id = '0;

    // 1 Reset values
    step();
    a_push_id = 3'd2; a_push_sel = 2'd1;
    expect_val(0, "rst_ready", 8'd1);
    expect_val(1, "rst_idle",  8'd1);
    expect_val(2, "rst_busy",  8'h00);
    expect_val(3, "rst_err",   8'd0);
    expect_val(6, "rst_idle_b", 8'd1);
    step();
    rst_n = 1'b1;

    // 2 Same ID, same port up to MaxTrans
    for (int k = 0; k < 8; k++) begin
      step();
      a_push(3'd3, 2'd2);
      expect_val(0, $sformatf("fill_ready_%0d", k), 8'd1);
    end
    step();
    a_push(3'd3, 2'd2);
    expect_val(0, "full_ready", 8'd0);
    expect_val(2, "full_busy",  8'h08);
    expect_val(1, "full_idle",  8'd0);
    step();
    a_push_id = 3'd3; a_push_sel = 2'd2;
    a_pop(3'd3);
    expect_val(0, "pop_no_bypass", 8'd0);
    step();
    expect_val(0, "pop_frees", 8'd1);
    do_reset();

    // 3 Port conflict
    step();
    a_push(3'd1, 2'd0);
    expect_val(0, "conf_first", 8'd1);
    step();
    a_push(3'd1, 2'd3);
    expect_val(0, "conf_block", 8'd0);
    step();
    a_push(3'd4, 2'd3);
    expect_val(0, "conf_other_id", 8'd1);
    step();
    a_push_id = 3'd1; a_push_sel = 2'd3;
    a_pop(3'd1);
    expect_val(0, "conf_still_block", 8'd0);
    expect_val(2, "conf_busy", 8'h12);
    step();
    expect_val(0, "conf_release", 8'd1);
    expect_val(2, "conf_busy2", 8'h10);
    do_reset();

    // 4 UniqueIds=1 ignores port mismatch
    step();
    b_push_valid = 1'b1; b_push_id = 3'd1; b_push_sel = 2'd0;
    expect_val(4, "uniq_first", 8'd1);
    step();
    b_push_valid = 1'b1; b_push_id = 3'd1; b_push_sel = 2'd3;
    expect_val(4, "uniq_second", 8'd1);
    step();
    b_pop_valid = 1'b1; b_pop_id = 3'd1;
    expect_val(5, "uniq_busy2", 8'h02);
    step();
    b_pop_valid = 1'b1; b_pop_id = 3'd1;
    expect_val(5, "uniq_busy1", 8'h02);
    step();
    expect_val(5, "uniq_busy0", 8'h00);
    expect_val(6, "uniq_idle", 8'd1);

    // 5 Simultaneous push+pop, then underflow
    step(); a_push(3'd5, 2'd0);
    step(); a_push(3'd5, 2'd0);
    step();
    a_push(3'd5, 2'd0);
    a_pop(3'd5);
    expect_val(0, "pp_ready", 8'd1);
    step(); a_pop(3'd5);
    expect_val(2, "pp_cnt2", 8'h20);
    step(); a_pop(3'd5);
    expect_val(2, "pp_cnt1", 8'h20);
    step(); a_pop(3'd6);
    expect_val(2, "pp_cnt0", 8'h00);
    expect_val(3, "uf_before", 8'd0);
    step();
    expect_val(3, "uf_set", 8'd1);
    expect_val(1, "uf_idle", 8'd1);
    step();
    expect_val(3, "uf_sticky", 8'd1);

    // 6 Async reset mid-stream with cnt[0]=4
    for (int k = 0; k < 4; k++) begin
      step();
      a_push(3'd0, 2'd1);
    end
    step();
    a_push_id = 3'd0; a_push_sel = 2'd2;
    expect_val(2, "pre_rst_busy", 8'h01);
    expect_val(0, "pre_rst_ready", 8'd0);
    step();
    a_push_id = 3'd0; a_push_sel = 2'd2;
    #1;
    rst_n = 1'b0;
    #1;
    expect_val(1, "arst_idle",  8'd1);
    expect_val(2, "arst_busy",  8'h00);
    expect_val(3, "arst_err",   8'd0);
    expect_val(0, "arst_ready", 8'd1);
    step();
    rst_n = 1'b1;
    step();
    step();
    if (exp_q.size() != 0) begin
      n_test++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
